// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock stream FIFO:
// counter/pointer widths and the wrap-around pointer increment.
package fifo_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Depth need not be a power of two, so wrap explicitly.
  function automatic int unsigned next_ptr(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sc_ctrl.sv
// FIFO control: pointers, occupancy, registered status flags, sticky errors.
// Ports: clk/rst, flush, wr_en/rd_en in; ptrs, accepts, flags, count out.
module fifo_sc_ctrl
  import fifo_pkg::*;
#(
  parameter int P_DEPTH    = 8,
  parameter int P_AF_LEVEL = P_DEPTH - 1,
  parameter int P_AE_LEVEL = 1,
  localparam int CW = count_width(P_DEPTH),
  localparam int PW = ptr_width(P_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [CW-1:0] count_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;

  // Flush drops both requests outright.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  assign wr_ptr_nxt = PW'(next_ptr(32'(wr_ptr), P_DEPTH));
  assign rd_ptr_nxt = PW'(next_ptr(32'(rd_ptr), P_DEPTH));

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end

  // Flags come from the next count so they stay in step with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CW'(P_DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(P_AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(P_AE_LEVEL));
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr_nxt;
        if (rd_acc)
          rd_ptr <= rd_ptr_nxt;
        overflow  <= overflow | (wr_en & full);
        underflow <= underflow | (rd_en & empty);
      end
    end
  end

endmodule

// File: rtl/fifo_sc_stream.sv
// Single-clock register FIFO, standard or first-word-fall-through read.
// Ports: i_clk/i_rst, i_flush, write (i_wr_en, i_data_in),
// read (i_rd_en, o_data_out), status flags, o_count, sticky errors.
module fifo_sc_stream
  import fifo_pkg::*;
#(
  parameter bit P_FALL_THROUGH = 1'b0,
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_DEPTH        = 8,
  parameter int P_AF_LEVEL     = P_DEPTH - 1,
  parameter int P_AE_LEVEL     = 1,
  localparam int CW = count_width(P_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_wr_en,
  input  logic [P_DATA_WIDTH-1:0] i_data_in,
  input  logic                    i_rd_en,
  output logic [P_DATA_WIDTH-1:0] o_data_out,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  output logic [CW-1:0]           o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int PW = ptr_width(P_DEPTH);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];

  fifo_sc_ctrl #(
    .P_DEPTH    (P_DEPTH),
    .P_AF_LEVEL (P_AF_LEVEL),
    .P_AE_LEVEL (P_AE_LEVEL)
  ) u_ctrl (
    .clk          (i_clk),
    .rst          (i_rst),
    .flush        (i_flush),
    .wr_en        (i_wr_en),
    .rd_en        (i_rd_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .full         (o_full),
    .empty        (o_empty),
    .almost_full  (o_almost_full),
    .almost_empty (o_almost_empty),
    .count        (o_count),
    .overflow     (o_overflow),
    .underflow    (o_underflow)
  );

  // Storage is not reset; contents survive flush.
  always_ff @(posedge i_clk) begin
    if (wr_acc)
      mem[wr_ptr] <= i_data_in;
  end

  if (P_FALL_THROUGH) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the
    // output is defined out of reset.
    assign o_data_out = o_empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [P_DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
        dout_q <= '0;
      else if (rd_acc)
        dout_q <= mem[rd_ptr];
    end

    assign o_data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_sc_stream.sv
// Bench for fifo_sc_stream: depth-5 standard, depth-5 FWFT and
// depth-8 (AF 6 / AE 2) instances share one stimulus stream.
module tb_fifo_sc_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [2:0] a_cnt, b_cnt;
  logic [3:0] c_cnt;

  int         n_pass = 0;
  int         n_tot = 0;
  int         m5 = 0;
  int         m8 = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         pend_a = 1'b0;

  always #5 clk = ~clk;

  fifo_sc_stream #(
    .P_FALL_THROUGH(1'b0), .P_DATA_WIDTH(8), .P_DEPTH(5)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en),
    .i_data_in(data_in), .i_rd_en(rd_en), .o_data_out(a_dout),
    .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af),
    .o_almost_empty(a_ae), .o_count(a_cnt), .o_overflow(a_ovf),
    .o_underflow(a_unf)
  );

  fifo_sc_stream #(
    .P_FALL_THROUGH(1'b1), .P_DATA_WIDTH(8), .P_DEPTH(5)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en),
    .i_data_in(data_in), .i_rd_en(rd_en), .o_data_out(b_dout),
    .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af),
    .o_almost_empty(b_ae), .o_count(b_cnt), .o_overflow(b_ovf),
    .o_underflow(b_unf)
  );

  fifo_sc_stream #(
    .P_FALL_THROUGH(1'b0), .P_DATA_WIDTH(8), .P_DEPTH(8),
    .P_AF_LEVEL(6), .P_AE_LEVEL(2)
  ) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en),
    .i_data_in(data_in), .i_rd_en(rd_en), .o_data_out(c_dout),
    .o_full(c_full), .o_empty(c_empty), .o_almost_full(c_af),
    .o_almost_empty(c_ae), .o_count(c_cnt), .o_overflow(c_ovf),
    .o_underflow(c_unf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp)
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // One clock of stimulus; queues get the words the FIFO must accept.
  task automatic step(input bit w, input bit r, input bit f,
                      input logic [7:0] d);
    bit a5, r5, a8, r8;
    wr_en = w; rd_en = r; flush = f; data_in = d;
    @(posedge clk);
    #1;
    if (f) begin
      m5 = 0; m8 = 0;
      qa.delete(); qb.delete();
    end else begin
      a5 = w && (m5 < 5); r5 = r && (m5 > 0);
      a8 = w && (m8 < 8); r8 = r && (m8 > 0);
      if (a5) begin
        qa.push_back(d); qb.push_back(d);
      end
      m5 = m5 + int'(a5) - int'(r5);
      m8 = m8 + int'(a8) - int'(r8);
    end
    chk("a_count", a_cnt, m5);
    chk("b_count", b_cnt, m5);
    chk("c_count", c_cnt, m8);
  endtask

  // Monitor: standard data lands the cycle after an accepted read;
  // FWFT data is the displayed word at the moment it is popped.
  always @(negedge clk) begin
    if (pend_a) begin
      if (qa.size() == 0) chk("a_sb_underrun", 1, 0);
      else chk("a_data", a_dout, qa.pop_front());
    end
    pend_a = rd_en && !a_empty && !flush && !rst;
    if (rd_en && !b_empty && !flush && !rst) begin
      if (qb.size() == 0) chk("b_sb_underrun", 1, 0);
      else chk("b_data", b_dout, qb.pop_front());
    end
  end

  initial begin
    #12;
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full", a_full, 0);
    chk("rst_a_count", a_cnt, 0);
    chk("rst_a_ae", a_ae, 1);
    chk("rst_a_af", a_af, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_unf", a_unf, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_dout", b_dout, 0);
    chk("rst_c_ae", c_ae, 1);
    rst = 1'b0;

    // Wrap: three fill/drain passes over a depth-5 array.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 5; i++)
        step(1, 0, 0, 8'((i + 1) * 17) ^ 8'(rep));
      chk("wrap_full", a_full, 1);
      chk("wrap_count", a_cnt, 5);
      for (int i = 0; i < 5; i++)
        step(0, 1, 0, 8'h00);
      chk("wrap_empty", a_empty, 1);
    end

    // FWFT first word.
    step(1, 0, 0, 8'hA5);
    chk("fwft_dout", b_dout, 8'hA5);
    chk("fwft_nempty", b_empty, 0);
    step(0, 1, 0, 8'h00);
    chk("fwft_empty", b_empty, 1);

    // Simultaneous read+write at full, empty and mid-range.
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 8'(i + 1));
    chk("sim_full", a_full, 1);
    step(1, 1, 0, 8'h66);
    chk("sim_full_cnt", a_cnt, 4);
    chk("sim_ovf", a_ovf, 1);
    chk("sim_unf0", a_unf, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 8'h00);
    chk("sim_empty", a_empty, 1);
    step(1, 1, 0, 8'h77);
    chk("sim_empty_cnt", a_cnt, 1);
    chk("sim_unf", a_unf, 1);
    step(1, 0, 0, 8'h88);
    step(1, 1, 0, 8'h99);
    chk("sim_mid_cnt", a_cnt, 2);

    // Flush beats write and read in the same cycle.
    step(1, 0, 0, 8'hAA);
    step(1, 0, 0, 8'hBB);
    chk("fl_pre_cnt", a_cnt, 4);
    chk("fl_pre_ovf", a_ovf, 1);
    step(1, 1, 1, 8'hEE);
    chk("fl_cnt", a_cnt, 0);
    chk("fl_empty", a_empty, 1);
    chk("fl_ovf", a_ovf, 0);
    chk("fl_unf", a_unf, 0);
    step(1, 0, 0, 8'h12);
    chk("fl_b_head", b_dout, 8'h12);
    step(0, 1, 0, 8'h00);

    // Almost flags on the depth-8 instance.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 8'(8'h30 + i));
      if (i == 1) chk("ae_at2", c_ae, 1);
      if (i == 2) chk("ae_at3", c_ae, 0);
      if (i == 4) chk("af_at5", c_af, 0);
      if (i == 5) chk("af_at6", c_af, 1);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00);
      if (i == 0) chk("af_dn5", c_af, 0);
      if (i == 2) chk("ae_dn3", c_ae, 0);
      if (i == 3) chk("ae_dn2", c_ae, 1);
    end

    // Asynchronous reset between edges.
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 0, 0, 8'h03);
    chk("ar_pre_cnt", a_cnt, 3);
    wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_a_cnt", a_cnt, 0);
    chk("ar_a_empty", a_empty, 1);
    chk("ar_a_full", a_full, 0);
    chk("ar_a_dout", a_dout, 0);
    chk("ar_b_empty", b_empty, 1);
    chk("ar_b_dout", b_dout, 0);
    chk("ar_c_cnt", c_cnt, 0);
    chk("ar_c_ae", c_ae, 1);
    m5 = 0; m8 = 0;
    qa.delete(); qb.delete();
    #10;
    rst = 1'b0;
    step(1, 0, 0, 8'h5A);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
